// File: rtl/operand_stream_gen.sv
// ============================================================================
// Module  : operand_stream_gen
// Brief   : Slices wide packages LSB-first into NUM_OPERANDS x OPW beats.
// Option  : OPSTREAM_PREFETCH_EN adds a one-package holding buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stream_gen #(
  parameter  int PACKAGE_WIDTH = 1600,
  parameter  int OPW           = 8,
  parameter  int NUM_OPERANDS  = 2,
  parameter  int CNT_W         = 16,
  localparam int BEAT_W        = NUM_OPERANDS * OPW,
  localparam int BEATS         = PACKAGE_WIDTH / BEAT_W,
  localparam int IDX_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pkt_valid_i,
  output logic                     pkt_ready_o,
  input  logic [PACKAGE_WIDTH-1:0] pkt_data_i,
  input  logic                     abort_i,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic [BEAT_W-1:0]        op_data_o,
  output logic                     op_last_o,
  output logic [IDX_W-1:0]         beat_idx_o,
  output logic                     pkt_done_o,
  output logic [CNT_W-1:0]         pkt_cnt_o,
  output logic                     busy_o
);

  localparam logic [0:0]       C_ST_IDLE   = 1'b0;
  localparam logic [0:0]       C_ST_STREAM = 1'b1;
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(BEATS - 1);

  if ((PACKAGE_WIDTH % BEAT_W) != 0) begin : g_width_check
    $error("operand_stream_gen: PACKAGE_WIDTH must be a multiple of NUM_OPERANDS*OPW");
  end

  if (BEATS < 2) begin : g_beats_check
    $error("operand_stream_gen: a package must contain at least two beats");
  end

  logic [0:0]               state_q, state_d;
  logic [PACKAGE_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]         beat_idx_q, beat_idx_d;
  logic                     done_q, done_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     init_q;
`ifdef OPSTREAM_PREFETCH_EN
  logic [PACKAGE_WIDTH-1:0] buf_q, buf_d;
  logic                     buf_full_q, buf_full_d;
`endif

  logic w_stream;
  logic w_op_fire;
  logic w_op_last;
  logic w_pkt_fire;

  assign w_stream  = (state_q == C_ST_STREAM);
  assign w_op_fire = w_stream && op_ready_i;
  assign w_op_last = w_stream && (beat_idx_q == C_LAST_IDX);

  // init_q keeps the input side closed while reset is asserted.
`ifdef OPSTREAM_PREFETCH_EN
  assign pkt_ready_o = init_q && !abort_i && (!w_stream || !buf_full_q);
`else
  assign pkt_ready_o = init_q && !abort_i && !w_stream;
`endif
  assign w_pkt_fire = pkt_valid_i && pkt_ready_o;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_idx_d = beat_idx_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
`ifdef OPSTREAM_PREFETCH_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif
    if (w_stream && abort_i) begin
      // Abort outranks everything, including a last-beat handshake.
      state_d    = C_ST_IDLE;
      shreg_d    = '0;
      beat_idx_d = '0;
`ifdef OPSTREAM_PREFETCH_EN
      buf_d      = '0;
      buf_full_d = 1'b0;
`endif
    end else if (w_stream) begin
`ifdef OPSTREAM_PREFETCH_EN
      if (w_pkt_fire) begin
        buf_d      = pkt_data_i;
        buf_full_d = 1'b1;
      end
`endif
      if (w_op_fire) begin
        if (w_op_last) begin
          done_d     = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          beat_idx_d = '0;
`ifdef OPSTREAM_PREFETCH_EN
          if (buf_full_q) begin
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
          end else if (w_pkt_fire) begin
            // Package arriving on the final beat skips the buffer.
            shreg_d    = pkt_data_i;
            buf_full_d = 1'b0;
          end else begin
            state_d = C_ST_IDLE;
            shreg_d = shreg_q >> BEAT_W;
          end
`else
          state_d = C_ST_IDLE;
          shreg_d = shreg_q >> BEAT_W;
`endif
        end else begin
          shreg_d    = shreg_q >> BEAT_W;
          beat_idx_d = beat_idx_q + IDX_W'(1);
        end
      end
    end else begin
      if (w_pkt_fire) begin
        shreg_d    = pkt_data_i;
        beat_idx_d = '0;
        state_d    = C_ST_STREAM;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= C_ST_IDLE;
      shreg_q    <= '0;
      beat_idx_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_idx_q <= beat_idx_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      init_q     <= 1'b1;
    end
  end

`ifdef OPSTREAM_PREFETCH_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  assign op_valid_o = w_stream;
  assign op_data_o  = shreg_q[BEAT_W-1:0];
  assign op_last_o  = w_op_last;
  assign beat_idx_o = beat_idx_q;
  assign pkt_done_o = done_q;
  assign pkt_cnt_o  = cnt_q;
  assign busy_o     = w_stream;

endmodule

`default_nettype wire
